// File: rtl/l2_setassoc_wb_cache_if.sv
// CPU-side and memory-side signal bundle for l2_setassoc_wb_cache.
// The slave modport is the cache; the master modport is the CPU plus memory model.
interface l2_setassoc_wb_cache_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
   logic                    req_i;
   logic                    wr_en_i;
   logic [ADDR_WIDTH-1:0]   addr_i;
   logic [DATA_WIDTH-1:0]   wr_data_i;
   logic [DATA_WIDTH/8-1:0] byte_en_i;
   logic                    busy_o;
   logic                    done_o;
   logic                    hit_o;
   logic [DATA_WIDTH-1:0]   rd_data_o;
   logic                    mem_req_o;
   logic                    mem_we_o;
   logic [ADDR_WIDTH-1:0]   mem_addr_o;
   logic [DATA_WIDTH-1:0]   mem_wr_data_o;
   logic                    mem_ack_i;
   logic [DATA_WIDTH-1:0]   mem_rd_data_i;

   modport slave (
      input  req_i, wr_en_i, addr_i, wr_data_i, byte_en_i, mem_ack_i, mem_rd_data_i,
      output busy_o, done_o, hit_o, rd_data_o, mem_req_o, mem_we_o, mem_addr_o, mem_wr_data_o
   );

   modport master (
      output req_i, wr_en_i, addr_i, wr_data_i, byte_en_i, mem_ack_i, mem_rd_data_i,
      input  busy_o, done_o, hit_o, rd_data_o, mem_req_o, mem_we_o, mem_addr_o, mem_wr_data_o
   );
endinterface

// File: rtl/l2_setassoc_wb_cache.sv
// Set-associative write-back, write-allocate cache, one word per line, true-LRU ages.
// Define L2_CACHE_STATS_EN to add saturating hit/miss counters (hit_cnt_o, miss_cnt_o).
module l2_setassoc_wb_cache #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_SETS   = 64,
   parameter int NUM_WAYS   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   l2_setassoc_wb_cache_if.slave bus,
   output logic [1:0]            dbg_state
`ifdef L2_CACHE_STATS_EN
   ,
   output logic [31:0]           hit_cnt_o,
   output logic [31:0]           miss_cnt_o
`endif
);
   // Handshakes: a request is taken when req_i=1 and busy_o=0 at a rising edge;
   // mem_req_o stays high with address/data held until a cycle where mem_ack_i=1.
   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int WAY_W = $clog2(NUM_WAYS);
   localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;
   localparam int BE_W  = DATA_WIDTH / 8;

   typedef enum logic [1:0] {IDLE = 2'd0, WRITEBACK = 2'd1, FILL = 2'd2, RESP = 2'd3} state_t;

   state_t state_q, state_d;

   logic                  valid_q [NUM_SETS][NUM_WAYS];
   logic                  dirty_q [NUM_SETS][NUM_WAYS];
   logic [WAY_W-1:0]      age_q   [NUM_SETS][NUM_WAYS];
   logic [TAG_W-1:0]      tag_q   [NUM_SETS][NUM_WAYS];
   logic [DATA_WIDTH-1:0] data_q  [NUM_SETS][NUM_WAYS];

   logic                  req_wr;
   logic [TAG_W-1:0]      req_tag;
   logic [IDX_W-1:0]      req_idx;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic [BE_W-1:0]       req_be;
   logic [WAY_W-1:0]      vic_way_q;
   logic [TAG_W-1:0]      vic_tag_q;
   logic [DATA_WIDTH-1:0] vic_data_q;

   logic                  done_q, hit_q;
   logic [DATA_WIDTH-1:0] rd_data_q;

   logic [IDX_W-1:0]      cur_idx;
   logic [TAG_W-1:0]      cur_tag;
   logic                  hit;
   logic [WAY_W-1:0]      hit_way;
   logic                  vic_found;
   logic [WAY_W-1:0]      vic_way;
   logic                  hit_acc, miss_acc, fill_ack;

   logic                  upd_en, upd_wr;
   logic [IDX_W-1:0]      upd_idx;
   logic [WAY_W-1:0]      upd_way;
   logic [DATA_WIDTH-1:0] upd_base, upd_wdata, merged;
   logic [BE_W-1:0]       upd_be;
   logic [WAY_W-1:0]      old_age;

   function automatic logic [DATA_WIDTH-1:0] merge_bytes(
      input logic [DATA_WIDTH-1:0] base,
      input logic [DATA_WIDTH-1:0] wdata,
      input logic [BE_W-1:0]       be
   );
      logic [DATA_WIDTH-1:0] r;
      r = base;
      for (int b = 0; b < BE_W; b++)
         if (be[b]) r[8*b +: 8] = wdata[8*b +: 8];
      return r;
   endfunction

   assign cur_idx = bus.addr_i[IDX_W+1:2];
   assign cur_tag = bus.addr_i[ADDR_WIDTH-1:IDX_W+2];

   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (!hit && valid_q[cur_idx][w] && tag_q[cur_idx][w] == cur_tag) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
   end

   // Lowest invalid way first; otherwise the oldest way (age NUM_WAYS-1).
   always_comb begin
      vic_found = 1'b0;
      vic_way   = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (!vic_found && !valid_q[cur_idx][w]) begin
            vic_found = 1'b1;
            vic_way   = WAY_W'(w);
         end
      end
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (!vic_found && age_q[cur_idx][w] == WAY_W'(NUM_WAYS - 1)) begin
            vic_found = 1'b1;
            vic_way   = WAY_W'(w);
         end
      end
   end

   assign hit_acc  = (state_q == IDLE) && bus.req_i && hit;
   assign miss_acc = (state_q == IDLE) && bus.req_i && !hit;
   assign fill_ack = (state_q == FILL) && bus.mem_ack_i;

   // One shared line-update path serves both a hit and the completion of a fill.
   assign upd_en    = hit_acc || fill_ack;
   assign upd_idx   = hit_acc ? cur_idx : req_idx;
   assign upd_way   = hit_acc ? hit_way : vic_way_q;
   assign upd_base  = hit_acc ? data_q[cur_idx][hit_way] : bus.mem_rd_data_i;
   assign upd_wr    = hit_acc ? bus.wr_en_i : req_wr;
   assign upd_wdata = hit_acc ? bus.wr_data_i : req_wdata;
   assign upd_be    = hit_acc ? bus.byte_en_i : req_be;
   assign merged    = merge_bytes(upd_base, upd_wdata, upd_wr ? upd_be : '0);
   assign old_age   = age_q[upd_idx][upd_way];

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:
            if (miss_acc)
               state_d = (valid_q[cur_idx][vic_way] && dirty_q[cur_idx][vic_way]) ? WRITEBACK : FILL;
         WRITEBACK: if (bus.mem_ack_i) state_d = FILL;
         FILL:      if (bus.mem_ack_i) state_d = RESP;
         RESP:      state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         done_q    <= 1'b0;
         hit_q     <= 1'b0;
         rd_data_q <= '0;
         for (int s = 0; s < NUM_SETS; s++) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
               valid_q[s][w] <= 1'b0;
               dirty_q[s][w] <= 1'b0;
               age_q[s][w]   <= WAY_W'(w);
            end
         end
      end else begin
         state_q <= state_d;
         done_q  <= upd_en;
         hit_q   <= hit_acc;
         if (upd_en) begin
            rd_data_q <= merged;
            valid_q[upd_idx][upd_way] <= 1'b1;
            // A fresh fill starts clean; a hit keeps any earlier dirtiness.
            dirty_q[upd_idx][upd_way] <= (hit_acc && dirty_q[upd_idx][upd_way]) ||
                                         (upd_wr && (|upd_be));
            for (int w = 0; w < NUM_WAYS; w++) begin
               if (WAY_W'(w) == upd_way)
                  age_q[upd_idx][w] <= '0;
               else if (age_q[upd_idx][w] < old_age)
                  age_q[upd_idx][w] <= age_q[upd_idx][w] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (upd_en) data_q[upd_idx][upd_way] <= merged;
      if (fill_ack) tag_q[upd_idx][upd_way] <= req_tag;
      if (miss_acc) begin
         req_wr     <= bus.wr_en_i;
         req_tag    <= cur_tag;
         req_idx    <= cur_idx;
         req_wdata  <= bus.wr_data_i;
         req_be     <= bus.byte_en_i;
         vic_way_q  <= vic_way;
         vic_tag_q  <= tag_q[cur_idx][vic_way];
         vic_data_q <= data_q[cur_idx][vic_way];
      end
   end

   assign bus.busy_o        = (state_q != IDLE);
   assign bus.done_o        = done_q;
   assign bus.hit_o         = hit_q;
   assign bus.rd_data_o     = rd_data_q;
   assign bus.mem_req_o     = (state_q == WRITEBACK) || (state_q == FILL);
   assign bus.mem_we_o      = (state_q == WRITEBACK);
   assign bus.mem_addr_o    = (state_q == WRITEBACK) ? {vic_tag_q, req_idx, 2'b00} :
                              (state_q == FILL)      ? {req_tag,   req_idx, 2'b00} : '0;
   assign bus.mem_wr_data_o = (state_q == WRITEBACK) ? vic_data_q : '0;
   assign dbg_state         = state_q;

`ifdef L2_CACHE_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_cnt_o  <= '0;
         miss_cnt_o <= '0;
      end else if (done_q) begin
         if (hit_q && hit_cnt_o != '1)        hit_cnt_o  <= hit_cnt_o + 1'b1;
         else if (!hit_q && miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_l2_setassoc_wb_cache.sv
// Directed bench for l2_setassoc_wb_cache: hits, fills, LRU writeback, busy drop, reset abort.
module tb_l2_setassoc_wb_cache;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  dbg_state;
   int          tests = 0;
   int          fails = 0;
   int          done_seen = 0;
`ifdef L2_CACHE_STATS_EN
   logic [31:0] hit_cnt, miss_cnt;
`endif

   l2_setassoc_wb_cache_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   l2_setassoc_wb_cache #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SETS(64), .NUM_WAYS(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
`ifdef L2_CACHE_STATS_EN
      ,
      .hit_cnt_o (hit_cnt),
      .miss_cnt_o(miss_cnt)
`endif
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (bus.done_o) done_seen++;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.req_i = 1'b0;
      bus.mem_ack_i = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Presents one request for one cycle; returns at accept edge + 1.
   task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be);
      @(posedge clk); #1;
      bus.req_i = 1'b1; bus.wr_en_i = wr; bus.addr_i = addr;
      bus.wr_data_i = wdata; bus.byte_en_i = be;
      @(posedge clk); #1;
      bus.req_i = 1'b0;
   endtask

   task automatic mem_serve(input string tag, input logic exp_we, input logic [31:0] exp_addr,
                            input logic [31:0] exp_wdata, input logic [31:0] rdata,
                            input int delay, input bit pulse_req);
      int n = 0;
      while (!bus.mem_req_o && n < 50) begin
         @(posedge clk); #1; n++;
      end
      check({tag, "_mem_req"}, bus.mem_req_o, 1'b1);
      check({tag, "_mem_we"}, bus.mem_we_o, exp_we);
      check({tag, "_mem_addr"}, bus.mem_addr_o, exp_addr);
      if (exp_we) check({tag, "_mem_wdata"}, bus.mem_wr_data_o, exp_wdata);
      for (int i = 0; i < delay; i++) begin
         if (pulse_req) begin
            bus.req_i = 1'b1; bus.wr_en_i = 1'b0; bus.addr_i = 32'h100 + 32'(i) * 32'h4;
         end
         @(posedge clk); #1;
         bus.req_i = 1'b0;
         if (pulse_req) begin
            check({tag, "_busy_hold"}, bus.busy_o, 1'b1);
            check({tag, "_addr_hold"}, bus.mem_addr_o, exp_addr);
         end
      end
      bus.mem_ack_i = 1'b1; bus.mem_rd_data_i = rdata;
      @(posedge clk); #1;
      bus.mem_ack_i = 1'b0; bus.mem_rd_data_i = '0;
   endtask

   task automatic wait_done(input string tag, input logic exp_hit, input logic [31:0] exp_data);
      int n = 0;
      while (!bus.done_o && n < 50) begin
         @(posedge clk); #1; n++;
      end
      check({tag, "_done"}, bus.done_o, 1'b1);
      check({tag, "_hit"}, bus.hit_o, exp_hit);
      check({tag, "_rd_data"}, bus.rd_data_o, exp_data);
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, bus.done_o, 1'b0);
   endtask

   initial begin
      int d0;
      bus.req_i = 0; bus.wr_en_i = 0; bus.addr_i = '0; bus.wr_data_i = '0;
      bus.byte_en_i = '0; bus.mem_ack_i = 0; bus.mem_rd_data_i = '0;
      do_reset();
      check("rst_busy", bus.busy_o, 1'b0);
      check("rst_done", bus.done_o, 1'b0);
      check("rst_hit", bus.hit_o, 1'b0);
      check("rst_mem_req", bus.mem_req_o, 1'b0);
      check("rst_mem_we", bus.mem_we_o, 1'b0);
      check("rst_rd_data", bus.rd_data_o, 32'h0);
      check("rst_mem_addr", bus.mem_addr_o, 32'h0);
      check("rst_mem_wdata", bus.mem_wr_data_o, 32'h0);

      // Cold miss, fill, then a one-cycle hit
      issue(1'b0, 32'h100, 32'h0, 4'h0);
      check("miss_busy", bus.busy_o, 1'b1);
      mem_serve("fill100", 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0);
      wait_done("miss100", 1'b0, 32'hDEADBEEF);
      issue(1'b0, 32'h100, 32'h0, 4'h0);
      check("hit100_mem_req", bus.mem_req_o, 1'b0);
      check("hit100_busy", bus.busy_o, 1'b0);
      wait_done("hit100", 1'b1, 32'hDEADBEEF);

      // Partial write hit, then read back
      issue(1'b1, 32'h100, 32'h00001234, 4'b0011);
      check("wrhit_mem_req", bus.mem_req_o, 1'b0);
      wait_done("wrhit", 1'b1, 32'hDEAD1234);
`ifdef L2_CACHE_STATS_EN
      check("stats_hit", hit_cnt, 32'd2);
      check("stats_miss", miss_cnt, 32'd1);
`endif
      issue(1'b0, 32'h100, 32'h0, 4'h0);
      wait_done("rdback", 1'b1, 32'hDEAD1234);
      issue(1'b1, 32'h100, 32'hFFFFFFFF, 4'b0000);
      wait_done("wr_be0", 1'b1, 32'hDEAD1234);

      // Fill set 0, then evict the dirty LRU line
      do_reset();
      issue(1'b1, 32'h000, 32'hCAFEF00D, 4'hF);
      mem_serve("fill000", 1'b0, 32'h000, 32'h0, 32'h11111111, 0, 1'b0);
      wait_done("wr000", 1'b0, 32'hCAFEF00D);
      issue(1'b0, 32'h100, 32'h0, 4'h0);
      mem_serve("fill100b", 1'b0, 32'h100, 32'h0, 32'hA1A1A1A1, 1, 1'b0);
      wait_done("rd100b", 1'b0, 32'hA1A1A1A1);
      issue(1'b0, 32'h200, 32'h0, 4'h0);
      mem_serve("fill200", 1'b0, 32'h200, 32'h0, 32'hA2A2A2A2, 0, 1'b0);
      wait_done("rd200", 1'b0, 32'hA2A2A2A2);
      issue(1'b0, 32'h300, 32'h0, 4'h0);
      mem_serve("fill300", 1'b0, 32'h300, 32'h0, 32'hA3A3A3A3, 2, 1'b0);
      wait_done("rd300", 1'b0, 32'hA3A3A3A3);
      issue(1'b0, 32'h400, 32'h0, 4'h0);
      mem_serve("wb000", 1'b1, 32'h000, 32'hCAFEF00D, 32'h0, 3, 1'b0);
      mem_serve("fill400", 1'b0, 32'h400, 32'h0, 32'h44444444, 0, 1'b0);
      wait_done("rd400", 1'b0, 32'h44444444);
      // Next LRU victim is the clean 0x100 line: straight to fill
      issue(1'b0, 32'h500, 32'h0, 4'h0);
      mem_serve("fill500", 1'b0, 32'h500, 32'h0, 32'h55555555, 0, 1'b0);
      wait_done("rd500", 1'b0, 32'h55555555);
      issue(1'b0, 32'h200, 32'h0, 4'h0);
      wait_done("hit200", 1'b1, 32'hA2A2A2A2);

      // Slow memory with requests pulsed while busy
      d0 = done_seen;
      issue(1'b0, 32'h1040, 32'h0, 4'h0);
      mem_serve("slow", 1'b0, 32'h1040, 32'h0, 32'h0BADF00D, 7, 1'b1);
      wait_done("slow", 1'b0, 32'h0BADF00D);
      repeat (3) @(posedge clk);
      #1;
      check("slow_done_count", 32'(done_seen - d0), 32'd1);
      check("slow_no_mem", bus.mem_req_o, 1'b0);

      // Reset during a fill aborts it and forgets cached lines
      issue(1'b0, 32'h700, 32'h0, 4'h0);
      check("abort_pre_req", bus.mem_req_o, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("abort_mem_req", bus.mem_req_o, 1'b0);
      check("abort_busy", bus.busy_o, 1'b0);
      check("abort_mem_addr", bus.mem_addr_o, 32'h0);
      @(posedge clk); #1 rst = 1'b0;
      issue(1'b0, 32'h200, 32'h0, 4'h0);
      mem_serve("post_rst", 1'b0, 32'h200, 32'h0, 32'h22222222, 0, 1'b0);
      wait_done("post_rst", 1'b0, 32'h22222222);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/l2_setassoc_wb_cache.md
L2_SETASSOC_WB_CACHE -- requirements
Module: l2_setassoc_wb_cache

Interface
REQ-001 The block SHALL provide parameter ADDR_WIDTH, default 32: byte address width.
REQ-002 The block SHALL provide parameter DATA_WIDTH, default 32: word width; one word per line.
REQ-003 The block SHALL provide parameter NUM_SETS, default 64: set count, power of two, at least 2.
REQ-004 The block SHALL provide parameter NUM_WAYS, default 4: ways per set, power of two, 2 to 8.
REQ-005 The block SHALL provide ports clk (in, 1, clock) and rst (in, 1, asynchronous active-high reset).
REQ-006 The block SHALL provide these CPU-side ports:
- req_i (in, 1): request.
- wr_en_i (in, 1): write.
- addr_i (in, ADDR_WIDTH): byte address.
- wr_data_i (in, DATA_WIDTH): write data.
- byte_en_i (in, DATA_WIDTH/8): byte mask.
REQ-007 The block SHALL provide these CPU-side outputs:
- busy_o (out, 1): not accepting.
- done_o (out, 1): one-cycle completion pulse.
- hit_o (out, 1): the completed access hit.
- rd_data_o (out, DATA_WIDTH): line word.
REQ-008 The block SHALL provide these memory-side ports:
- mem_req_o (out, 1).
- mem_we_o (out, 1).
- mem_addr_o (out, ADDR_WIDTH).
- mem_wr_data_o (out, DATA_WIDTH).
- mem_ack_i (in, 1).
- mem_rd_data_i (in, DATA_WIDTH).

Function
REQ-009 The address SHALL decompose as offset addr_i[1:0] (ignored), index addr_i[$clog2(NUM_SETS)+1:2] and tag equal to the remaining upper bits.
REQ-010 The block SHALL accept req_i only in IDLE; req_i in any other state SHALL be ignored, and busy_o SHALL equal (state != IDLE).
REQ-011 The FSM SHALL have states IDLE, WRITEBACK, FILL and RESP.
REQ-012 On an accepted hit, the block SHALL stay in IDLE and pulse done_o with hit_o=1 in the next cycle; hit latency SHALL be 1 cycle.
REQ-013 On an accepted miss, the block SHALL latch the request, select a victim, and go to WRITEBACK if the victim is valid and dirty, else to FILL.
REQ-014 In WRITEBACK, the block SHALL assert mem_req_o=1 and mem_we_o=1 with the victim address and data held stable until mem_ack_i, then go to FILL.
REQ-015 In FILL, the block SHALL assert mem_req_o=1 and mem_we_o=0 with the word-aligned request address until mem_ack_i, then install the line (valid=1, tag), merge write bytes, and go to RESP.
REQ-016 In RESP, the block SHALL pulse done_o with hit_o=0 and return to IDLE.
REQ-017 The block SHALL ignore mem_ack_i outside WRITEBACK and FILL.
REQ-018 Writes SHALL update only the bytes set in byte_en_i and SHALL set dirty; a write with byte_en_i=0 SHALL leave data and dirty unchanged but SHALL still update LRU.
REQ-019 rd_data_o SHALL present the full post-write line word, registered and valid while done_o=1.
REQ-020 Victim selection SHALL take the lowest-index invalid way, else the way with age NUM_WAYS-1.
REQ-021 Each way SHALL carry a $clog2(NUM_WAYS)-bit age forming a permutation per set; on access, the used way's age SHALL become 0 and ages below its old age SHALL increment.

Reset
REQ-022 rst SHALL immediately force IDLE and drive busy_o, done_o, hit_o, mem_req_o and mem_we_o to 0, and rd_data_o, mem_addr_o and mem_wr_data_o to 0.
REQ-023 rst SHALL clear all valid and dirty bits and set age[s][w]=w; data and tag contents after reset SHALL be don't-care.
REQ-024 Reset mid-transaction SHALL abandon the transaction without a writeback.

Configuration
REQ-025 With L2_CACHE_STATS_EN defined, the block SHALL add outputs hit_cnt_o and miss_cnt_o (32 bits each), reset to 0, incremented once per done_o according to hit_o and saturating at all-ones.
REQ-026 Without L2_CACHE_STATS_EN, those ports and counters SHALL be absent, with no other behaviour change.

Verification
REQ-027 Post-reset read of 0x100 -> FILL with mem_addr_o=0x100; ack with 0xDEADBEEF -> done_o, hit_o=0, rd_data_o=0xDEADBEEF; re-read -> done_o 1 cycle later with hit_o=1 and no mem_req_o.
REQ-028 Write 0x0000_1234 to 0x100 with byte_en 0011 -> hit, no memory traffic; a following read returns 0xDEAD1234.
REQ-029 Defaults: write 0x000 then read 0x100, 0x200 and 0x300 (same set 0); access 0x400 -> WRITEBACK of address 0x000 with mem_we_o=1 and the dirty data, then FILL of 0x400.
REQ-030 mem_ack_i delayed 7 cycles with req_i pulsed meanwhile -> busy_o=1 throughout, extra requests dropped, exactly one done_o.
REQ-031 rst asserted during FILL -> mem_req_o=0 in the same cycle; after release, earlier-cached addresses miss.
REQ-032 With L2_CACHE_STATS_EN, REQ-027 followed by REQ-028 -> hit_cnt_o=2 and miss_cnt_o=1.
